// File: rtl/serial_tx_framer.sv
// serial_tx_framer: multi-lane transmit framer feeding SER_WIDTH:1 serializers.
// Emits train / idle / sync / payload / check words, one word per lane per clk.

// Per-lane bit-order stage: passes the word through, or bit-reverses it so
// that the lane MSB leaves the serializer first.
module serial_tx_framer_lane #(
  parameter int SER_WIDTH = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic [SER_WIDTH-1:0] din,
  output logic [SER_WIDTH-1:0] dout
);
  if (LSB_FIRST) begin : g_pass
    assign dout = din;
  end else begin : g_rev
    for (genvar b = 0; b < SER_WIDTH; b++) begin : g_bit
      assign dout[b] = din[SER_WIDTH-1-b];
    end
  end
endmodule

module serial_tx_framer #(
  parameter int                   NUM_LANES     = 1,
  parameter int                   SER_WIDTH     = 8,
  parameter int                   FRAME_LEN     = 16,
  parameter logic [SER_WIDTH-1:0] TRAIN_PATTERN = 8'h0F,
  parameter logic [SER_WIDTH-1:0] SYNC_WORD     = 8'hBC,
  parameter logic [SER_WIDTH-1:0] IDLE_WORD     = 8'h3C,
  parameter bit                   LSB_FIRST     = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           train,
  input  logic [NUM_LANES*SER_WIDTH-1:0] in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [NUM_LANES*SER_WIDTH-1:0] ser_data,
  output logic                           frame_start,
  output logic                           frame_abort,
  output logic [15:0]                    underrun_count
);
  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_LEN - 1);

  typedef logic [NUM_LANES-1:0][SER_WIDTH-1:0] lanes_t;

  typedef struct packed {
    lanes_t data;
    logic   start;
    logic   abort;
  } out_t;

  typedef enum logic [2:0] {S_TRAIN, S_IDLE, S_SYNC, S_PAYLOAD, S_CHECK} state_t;

  state_t        state_q, state_d;
  lanes_t        in_lanes, word_sel, word_ord, checksum_q;
  logic [CW-1:0] beat_cnt_q;
  out_t          out_q, out_d;
  logic          accept, underrun, start_d, abort_d, ck_clr;

  assign in_lanes = in_data;
  // Ready depends only on state and train so the source never sees a loop.
  assign in_ready = (state_q == S_PAYLOAD) && !train;
  assign accept   = in_ready && in_valid;
  assign ck_clr   = (state_q == S_SYNC);

  // Per-lane bit-order stage applied to every word type.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    serial_tx_framer_lane #(.SER_WIDTH(SER_WIDTH), .LSB_FIRST(LSB_FIRST)) u_lane (
      .din  (word_sel[k]),
      .dout (word_ord[k])
    );
  end

  // Next state and next output word; train overrides everything.
  always_comb begin
    state_d  = state_q;
    word_sel = {NUM_LANES{IDLE_WORD}};
    start_d  = 1'b0;
    abort_d  = 1'b0;
    underrun = 1'b0;
    if (train) begin
      state_d  = S_TRAIN;
      word_sel = {NUM_LANES{TRAIN_PATTERN}};
      abort_d  = (state_q == S_SYNC) || (state_q == S_PAYLOAD) || (state_q == S_CHECK);
    end else begin
      case (state_q)
        S_TRAIN: begin
          word_sel = {NUM_LANES{TRAIN_PATTERN}};
          state_d  = S_IDLE;
        end
        S_IDLE: begin
          if (in_valid) state_d = S_SYNC;
        end
        S_SYNC: begin
          word_sel = {NUM_LANES{SYNC_WORD}};
          start_d  = 1'b1;
          state_d  = S_PAYLOAD;
        end
        S_PAYLOAD: begin
          if (in_valid) begin
            word_sel = in_lanes;
            if (beat_cnt_q == LAST_BEAT) state_d = S_CHECK;
          end else begin
            underrun = 1'b1;
          end
        end
        S_CHECK: begin
          word_sel = checksum_q;
          state_d  = in_valid ? S_SYNC : S_IDLE;
        end
        default: state_d = S_TRAIN;
      endcase
    end
  end

  assign out_d = '{data: word_ord, start: start_d, abort: abort_d};

  // State, frame accumulators, output register and underrun counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_TRAIN;
      checksum_q     <= '0;
      beat_cnt_q     <= '0;
      out_q          <= '0;
      underrun_count <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      if (ck_clr) begin
        checksum_q <= '0;
        beat_cnt_q <= '0;
      end else if (accept) begin
        checksum_q <= checksum_q ^ in_lanes;
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end
      if (underrun && (underrun_count != 16'hFFFF))
        underrun_count <= underrun_count + 16'd1;
    end
  end

  assign ser_data    = out_q.data;
  assign frame_start = out_q.start;
  assign frame_abort = out_q.abort;
endmodule
